// File: rtl/si_tx_fifo_pkg.sv
// Shared constants for the SI transmit FIFO: payload width, depth, almost-full level.
// Latency: n/a (constants only).
// Backpressure: n/a.
package si_tx_fifo_pkg;

  // SI payload width
  localparam int TX_WIDTH            = 8;
  // log2 of total FIFO capacity in words (RAM plus output register)
  localparam int TX_FIFO_DEPTH_LOG2  = 9;
  // level at or above which almost_full is raised
  localparam int TX_FIFO_ALMOST_FULL = 480;
  // the end-of-frame flag sits directly above the payload in each stored word
  localparam int TX_EOF_BIT          = TX_WIDTH;

  // eof bit index for an arbitrary payload width
  function automatic int eof_bit(input int data_width);
    return data_width;
  endfunction

endpackage

// File: rtl/si_fifo_ram.sv
// Simple dual-port RAM, one write port and one registered read port (maps onto SB_RAM40_4K).
// Latency: read data appears one clk after rd_en; write lands on the clk edge.
// Backpressure: none; the caller never reads an address being written in the same cycle.
module si_fifo_ram
  import si_tx_fifo_pkg::*;
#(
  parameter int WIDTH      = TX_WIDTH + 1,
  parameter int ADDR_WIDTH = TX_FIFO_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_dat,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_dat
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [WIDTH-1:0] mem [DEPTH];

  // write port
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
  end

  // registered read port; holds its word while rd_en is low
  always_ff @(posedge clk) begin
    if (rd_en) rd_dat <= mem[rd_addr];
  end

endmodule

// File: rtl/si_tx_fifo.sv
// Elastic SI tx buffer with per-word eof and frame count; SI_TX_FIFO_FRAME_MODE_EN holds output until a whole frame is stored.
// Latency: out_rdy rises 2 clk after in_ack into an empty FIFO; 1 word/clk streaming.
// Backpressure: in_ack = in_rdy && !full (no write-through when full); out_ack honoured only while out_rdy.
module si_tx_fifo
  import si_tx_fifo_pkg::*;
#(
  parameter int DATA_WIDTH        = TX_WIDTH,
  parameter int DEPTH_LOG2        = TX_FIFO_DEPTH_LOG2,
  parameter int ALMOST_FULL_LEVEL = TX_FIFO_ALMOST_FULL
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_eof,
  input  logic                  in_rdy,
  output logic                  in_ack,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_eof,
  output logic                  out_rdy,
  input  logic                  out_ack,
  output logic [DEPTH_LOG2:0]   level,
  output logic [DEPTH_LOG2:0]   frames_pending,
  output logic                  almost_full
);

  localparam int              LW      = DEPTH_LOG2 + 1;
  localparam int              EOF_BIT = eof_bit(DATA_WIDTH);
  localparam logic [LW-1:0]   CAP     = LW'(1) << DEPTH_LOG2;
  localparam logic [LW-1:0]   AF_LVL  = LW'(ALMOST_FULL_LEVEL);

  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DATA_WIDTH:0]   rd_dat;
  logic                  out_vld;   // RAM read register currently holds the head word
  logic                  full;
  logic                  ram_empty;
  logic                  out_take;
  logic                  fetch;
  logic                  frame_ok;
  logic [LW-1:0]         level_nxt;
  logic [LW-1:0]         frames_nxt;

  // The RAM never holds more than 2**DEPTH_LOG2-1 words (the last slot of
  // capacity is the output register), so equal pointers always mean empty.
  assign full      = (level == CAP);
  assign ram_empty = (wr_ptr == rd_ptr);
  assign in_ack    = rst && in_rdy && !full;
  assign out_take  = out_rdy && out_ack;
  assign fetch     = !ram_empty && (!out_vld || out_take);

  assign level_nxt  = level + LW'(in_ack) - LW'(out_take);
  assign frames_nxt = frames_pending + LW'(in_ack && in_eof) - LW'(out_take && out_eof);

`ifdef SI_TX_FIFO_FRAME_MODE_EN
  logic in_frame;   // a frame has started leaving and its eof has not been consumed yet

  // track whether the output is part-way through a frame
  always_ff @(posedge clk) begin
    if (!rst) begin
      in_frame <= 1'b0;
    end else if (out_take && out_eof) begin
      in_frame <= 1'b0;
    end else if (out_rdy) begin
      in_frame <= 1'b1;
    end
  end

  // full clause lets frames longer than the capacity drain instead of deadlocking
  assign frame_ok = in_frame || (frames_pending != '0) || full;
`else
  assign frame_ok = 1'b1;
`endif

  // The RAM's read register doubles as the output register; it reads as zero while empty.
  assign out_rdy  = out_vld && frame_ok;
  assign out_data = out_vld ? rd_dat[DATA_WIDTH-1:0] : '0;
  assign out_eof  = out_vld && rd_dat[EOF_BIT];

  si_fifo_ram #(
    .WIDTH      (DATA_WIDTH + 1),
    .ADDR_WIDTH (DEPTH_LOG2)
  ) u_ram (
    .clk     (clk),
    .wr_en   (in_ack),
    .wr_addr (wr_ptr),
    .wr_dat  ({in_eof, in_data}),
    .rd_en   (fetch),
    .rd_addr (rd_ptr),
    .rd_dat  (rd_dat)
  );

  // pointers, output-valid flag and occupancy/frame counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      out_vld        <= 1'b0;
      level          <= '0;
      frames_pending <= '0;
      almost_full    <= 1'b0;
    end else begin
      if (in_ack) wr_ptr <= wr_ptr + 1'b1;
      if (fetch)  rd_ptr <= rd_ptr + 1'b1;
      if (fetch)         out_vld <= 1'b1;
      else if (out_take) out_vld <= 1'b0;
      level          <= level_nxt;
      frames_pending <= frames_nxt;
      almost_full    <= (level_nxt >= AF_LVL);
    end
  end

endmodule

// File: tb/tb_si_tx_fifo.sv
// Randomised + directed bench for si_tx_fifo with a queue-based reference model and scoreboard.
// Latency model: head word usable at max(accept+2, previous consume+1).
// Backpressure model: accept while fewer than 512 words held; frame gating when SI_TX_FIFO_FRAME_MODE_EN.
module tb_si_tx_fifo;

  localparam int CAP = 512;
  localparam int AFL = 480;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_eof = 1'b0;
  logic       in_rdy = 1'b0;
  logic       in_ack;
  logic [7:0] out_data;
  logic       out_eof;
  logic       out_rdy;
  logic       out_ack = 1'b0;
  logic [9:0] level;
  logic [9:0] frames_pending;
  logic       almost_full;

  si_tx_fifo dut (
    .clk            (clk),
    .rst            (rst),
    .in_data        (in_data),
    .in_eof         (in_eof),
    .in_rdy         (in_rdy),
    .in_ack         (in_ack),
    .out_data       (out_data),
    .out_eof        (out_eof),
    .out_rdy        (out_rdy),
    .out_ack        (out_ack),
    .level          (level),
    .frames_pending (frames_pending),
    .almost_full    (almost_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       e;
    int         acc;
  } word_t;

  word_t sb[$];
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  int    last_take = -1000;
  bit    in_frame_m = 1'b0;
  bit    after_rst = 1'b0;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  // Reference model + scoreboard, evaluated mid-cycle while inputs are stable
  always @(negedge clk) begin : monitor
    int  sz;
    int  nfr;
    bit  exp_ack;
    bit  avail;
    bit  gate;
    bit  exp_rdy;
    bit  take;
    sz  = sb.size();
    nfr = 0;
    foreach (sb[i]) if (sb[i].e) nfr++;

    chk("level", int'(level), sz);
    chk("frames_pending", int'(frames_pending), nfr);
    chk("almost_full", int'(almost_full), (sz >= AFL) ? 1 : 0);
    if (after_rst) begin
      chk("out_data_rst", int'(out_data), 0);
      chk("out_eof_rst", int'(out_eof), 0);
    end

    exp_ack = rst && in_rdy && (sz < CAP);
    chk("in_ack", int'(in_ack), int'(exp_ack));

    avail = (sz > 0) && (cyc >= imax(sb[0].acc + 2, last_take + 1));
`ifdef SI_TX_FIFO_FRAME_MODE_EN
    gate = (nfr > 0) || (sz == CAP) || in_frame_m;
`else
    gate = 1'b1;
`endif
    exp_rdy = avail && gate;
    chk("out_rdy", int'(out_rdy), int'(exp_rdy));

    take = exp_rdy && out_ack && rst;
    if (take) begin
      chk("out_data", int'(out_data), int'(sb[0].d));
      chk("out_eof", int'(out_eof), int'(sb[0].e));
    end
`ifdef SI_TX_FIFO_FRAME_MODE_EN
    if (exp_rdy && out_ack && sb[0].e) in_frame_m = 1'b0;
    else if (exp_rdy)                  in_frame_m = 1'b1;
`endif
    if (take) begin
      void'(sb.pop_front());
      last_take = cyc;
    end
    if (exp_ack) sb.push_back('{d: in_data, e: in_eof, acc: cyc});

    if (!rst) begin
      sb.delete();
      last_take  = -1000;
      in_frame_m = 1'b0;
    end
    after_rst = !rst;
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word and hold it until accepted (bounded)
  task automatic offer(input logic [7:0] d, input logic e);
    int n;
    in_rdy  = 1'b1;
    in_data = d;
    in_eof  = e;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ack && n < 4000);
    checks++;
    if (!in_ack) begin
      failures++;
      $display("FAIL offer_timeout data=%0d actual=no_ack required=ack", d);
    end
    @(posedge clk);
    #1;
    in_rdy = 1'b0;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    bit acked;
    // 1: reset held with a word on offer
    rst = 1'b0; in_rdy = 1'b1; in_data = 8'h11;
    repeat (3) tick();
    rst = 1'b1; in_rdy = 1'b0;
    tick();

    // 2: single eof word through an empty FIFO
    out_ack = 1'b1;
    offer(8'hA5, 1'b1);
    repeat (5) tick();

    // 3: fill to capacity, crossing the pointer wrap
    out_ack = 1'b0;
    for (int i = 0; i < CAP; i++) offer(8'(i), (i == CAP - 1));

    // 4: 513th offer refused, also while a read happens; accepted the cycle after
    fork
      offer(8'h77, 1'b1);
      begin
        repeat (3) tick();
        out_ack = 1'b1;
        tick();
        out_ack = 1'b0;
      end
    join
    tick();
    out_ack = 1'b1;
    repeat (CAP + 10) tick();

    // 5: 10 words without eof, then the closing eof word
    for (int i = 0; i < 10; i++) offer(8'(8'h40 + i), 1'b0);
    repeat (4) tick();
    offer(8'h4A, 1'b1);
    repeat (16) tick();

    // random traffic: fill-biased first half, drain-biased second half
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      acked = in_ack;
      @(posedge clk);
      #1;
      if (!in_rdy || acked) begin
        in_rdy  = ($urandom_range(0, 2) != 0);
        in_data = 8'($urandom);
        in_eof  = ($urandom_range(0, 7) == 0);
      end
      out_ack = (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
    end
    in_rdy = 1'b0;
    out_ack = 1'b1;
    repeat (600) tick();

    // 6: reset in the middle of a drain, with a word on offer
    rst = 1'b0;
    tick();
    rst = 1'b1;
    out_ack = 1'b0;
    for (int i = 0; i < 100; i++) offer(8'(i), (i % 10 == 9));
    out_ack = 1'b1;
    repeat (3) tick();
    in_rdy = 1'b1; in_data = 8'h99; in_eof = 1'b1;
    rst = 1'b0;
    tick();
    rst = 1'b1; in_rdy = 1'b0;
    tick();
    offer(8'h3C, 1'b1);
    repeat (10) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
